data_ram_mmio: RTL and testbench

//  Responder for the core's data-memory port (ce/we/addr/sel/data). Decodes each access to either on-chip

---
 rtl/data_ram_mmio.sv | 121 ++++++++++++
 tb/tb_data_ram_mmio.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_ram_mmio.sv
// Data-memory responder: word RAM plus MMIO block (GPIO, prescaled timer, compare irq).
// Ports: clk, rst (async high), ce_i/we_i/addr_i/sel_i/data_i in; data_o, gpio_o, irq_o out.
module data_ram_mmio #(
  parameter int         ADDR_WIDTH  = 10,
  parameter logic [3:0] MMIO_NIBBLE = 4'h1,
  parameter int         PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] gpio_o,
  output logic        irq_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [31:0] mem [DEPTH];

  logic                  mmio;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            rsel;

  logic [31:0] gpio;
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        flag;
  logic        ie;
  logic [15:0] pre;
  logic        tick;
  logic        match;

  assign mmio  = (addr_i[31:28] == MMIO_NIBBLE);
  assign wr    = ce_i & we_i;
  assign rd    = ce_i & ~we_i;
  assign idx   = addr_i[ADDR_WIDTH+1:2];
  assign rsel  = addr_i[3:2];
  assign tick  = (pre == PRE_MAX);
  // Compare uses the pre-increment count.
  assign match = tick && (cnt == cmp);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (sel[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // RAM is never reset; a write overlapping rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr && !mmio) begin
      for (int k = 0; k < 4; k++)
        if (sel_i[k]) mem[idx][8*k +: 8] <= data_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio <= '0;
      cnt  <= '0;
      cmp  <= '1;
      flag <= 1'b0;
      ie   <= 1'b0;
      pre  <= '0;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) cnt <= cnt + 32'd1;
      if (wr && mmio) begin
        case (rsel)
          2'd0: gpio <= merge(gpio, data_i, sel_i);
          2'd1: begin
            // Software load overrides the increment and restarts the prescaler.
            cnt <= merge(cnt, data_i, sel_i);
            if (|sel_i) pre <= '0;
          end
          2'd2: cmp <= merge(cmp, data_i, sel_i);
          default: begin
            if (sel_i[0]) begin
              ie <= data_i[1];
              if (data_i[0]) flag <= 1'b0;
            end
          end
        endcase
      end
      // Set after the W1C so a coincident match keeps the flag.
      if (match) flag <= 1'b1;
    end
  end

  always_comb begin
    data_o = '0;
    if (!rst && rd) begin
      if (mmio) begin
        case (rsel)
          2'd0:    data_o = gpio;
          2'd1:    data_o = cnt;
          2'd2:    data_o = cmp;
          default: data_o = {30'd0, ie, flag};
        endcase
      end else begin
        data_o = mem[idx];
      end
    end
  end

  assign gpio_o = gpio;
  assign irq_o  = flag & ie;

endmodule

// File: tb/tb_data_ram_mmio.sv
// Scoreboard bench for data_ram_mmio: two instances (PRESCALE 1 and 4) on a shared bus.
// Expectations are queued by the driver and popped by a negedge monitor.
module tb_data_ram_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2, gpio1, gpio2;
  logic        irq1, irq2;

  always #5 clk = ~clk;

  data_ram_mmio #(.ADDR_WIDTH(10), .MMIO_NIBBLE(4'h1), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
    .sel_i(sel), .data_i(wdata), .data_o(rdata1), .gpio_o(gpio1),
    .irq_o(irq1)
  );

  data_ram_mmio #(.ADDR_WIDTH(10), .MMIO_NIBBLE(4'h1), .PRESCALE(4)) u2 (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
    .sel_i(sel), .data_i(wdata), .data_o(rdata2), .gpio_o(gpio2),
    .irq_o(irq2)
  );

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   compared = 0;
  int   mism = 0;

  localparam logic [31:0] GPIO = 32'h1000_0000;
  localparam logic [31:0] CNT  = 32'h1000_0004;
  localparam logic [31:0] CMP  = 32'h1000_0008;
  localparam logic [31:0] STAT = 32'h1000_000C;

  function automatic logic [31:0] pick(input int d, input int k);
    logic [31:0] v;
    case (k)
      0:       v = d ? rdata2 : rdata1;
      1:       v = d ? gpio2 : gpio1;
      default: v = {31'd0, d ? irq2 : irq1};
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < nchk; i++) begin
      if (q.size() == 0) begin
        mism++;
        $display("FAIL underflow: no expectation queued");
      end else begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        act = pick(e.dut, e.kind);
        compared++;
        if (act !== e.exp) begin
          mism++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input int d, input int k,
                          input logic [31:0] e, input string n);
    exp_t x;
    x.dut = d; x.kind = k; x.exp = e; x.name = n;
    q.push_back(x);
    nchk++;
  endtask

  task automatic op(input logic c, input logic w, input logic [31:0] a,
                    input logic [3:0] s, input logic [31:0] d);
    ce = c; we = w; addr = a; sel = s; wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    nchk = 0;
    op(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    op(1'b1, 1'b1, a, s, d);
    expect_v(0, 0, 32'h0, "wr_data0");
    step();
  endtask

  task automatic rd(input int d, input logic [31:0] a,
                    input logic [31:0] e, input string n);
    op(1'b1, 1'b0, a, 4'h0, 32'h0);
    expect_v(d, 0, e, n);
  endtask

  initial begin
    rst = 1'b1;
    op(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rd(0, 32'h10, 32'h0, "rst_data");
    expect_v(0, 1, 32'h0, "rst_gpio");
    expect_v(0, 2, 32'h0, "rst_irq");
    expect_v(1, 2, 32'h0, "rst_irq2");
    step();
    rst = 1'b0;

    // RAM byte lanes
    wr(32'h10, 4'hF, 32'h1122_3344);
    wr(32'h10, 4'b0100, 32'hAABB_CCDD);
    rd(0, 32'h10, 32'h11BB_3344, "ram_lanes"); step();

    // Null operations
    wr(32'h10, 4'h0, 32'hFFFF_FFFF);
    rd(0, 32'h10, 32'h11BB_3344, "null_sel"); step();
    op(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    expect_v(0, 0, 32'h0, "ce0_data"); step();

    // Address aliasing
    wr(32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
    rd(0, 32'h0, 32'hDEAD_BEEF, "alias"); step();

    // GPIO and asynchronous reset between edges
    wr(GPIO, 4'b0001, 32'h0000_00A5);
    expect_v(0, 1, 32'h0000_00A5, "gpio"); step();
    rst = 1'b1;
    expect_v(0, 1, 32'h0, "gpio_async_rst");
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();
    rd(0, 32'h10, 32'h11BB_3344, "ram_keeps"); step();

    // Timer wrap and irq, PRESCALE=1
    wr(CMP, 4'hF, 32'h0000_0001);
    wr(STAT, 4'b0001, 32'h0000_0002);
    wr(CNT, 4'hF, 32'hFFFF_FFFE);
    rd(0, CNT, 32'hFFFF_FFFE, "cnt_load"); step();
    rd(0, CNT, 32'hFFFF_FFFF, "cnt_max"); step();
    rd(0, CNT, 32'h0, "cnt_wrap");
    expect_v(0, 2, 32'h0, "irq_pre"); step();
    rd(0, CNT, 32'h1, "cnt_one"); step();
    rd(0, STAT, 32'h3, "status_match");
    expect_v(0, 2, 32'h1, "irq_set"); step();
    wr(STAT, 4'b0001, 32'h0000_0003);
    rd(0, STAT, 32'h2, "status_w1c");
    expect_v(0, 2, 32'h0, "irq_clr"); step();

    // PRESCALE=4 on the second instance
    wr(CNT, 4'hF, 32'h0000_000A);
    for (int i = 0; i < 4; i++) begin
      rd(1, CNT, 32'h0000_000A, "p4_hold"); step();
    end
    for (int i = 0; i < 3; i++) begin
      rd(1, CNT, 32'h0000_000B, "p4_step"); step();
    end
    wr(CNT, 4'hF, 32'h0000_0100);
    rd(1, CNT, 32'h0000_0100, "p4_wr_tick"); step();
    wr(CMP, 4'hF, 32'h0000_0100);
    wr(STAT, 4'b0001, 32'h0000_0002);
    wr(STAT, 4'b0001, 32'h0000_0003);
    rd(1, STAT, 32'h3, "p4_set_wins");
    expect_v(1, 2, 32'h1, "p4_irq"); step();
    wr(STAT, 4'b0001, 32'h0000_0001);
    rd(1, STAT, 32'h0, "p4_clear");
    expect_v(1, 2, 32'h0, "p4_irq_off"); step();

    step();
    step();
    if (q.size() != 0) begin
      mism++;
      $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
